// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared constants for the truth-table sweeper.
// Holds the FSM state encoding and the table geometry.
package truth_table_pkg;

  localparam int N_IN     = 3;
  localparam int TT_WIDTH = 1 << N_IN;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/hold_counter.sv
// hold_counter: counts clocks a vector is held; flags the last one.
// Ports: clk, rst (sync, high), clear, en, terminal (count==HOLD-1).
module hold_counter #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign terminal = (r_cnt == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      // wraps on terminal, so it never exceeds HOLD_CYCLES-1
      r_cnt <= terminal ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives {a,b,c}=0..7, samples y_in on the
// last hold cycle of each vector and presents the 8-bit table.
// Ports: clk, rst (sync, high), start, y_in -> a, b, c, vec_idx,
//        busy, done, truth_table (bit i = y for {a,b,c}=i).
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                y_in,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic [N_IN-1:0]     vec_idx,
  output logic                busy,
  output logic                done,
  output logic [TT_WIDTH-1:0] truth_table
);

  state_t              r_state;
  state_t              w_next;
  logic [N_IN-1:0]     r_vec;
  logic [TT_WIDTH-1:0] r_tt;
  logic                w_term;
  logic                w_drive;
  logic                w_go;
  logic                w_last;

  assign w_drive = (r_state == ST_DRIVE);
  // start is only honoured outside a sweep
  assign w_go    = start && !w_drive;
  assign w_last  = (r_vec == N_IN'(TT_WIDTH - 1));

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clear    (!w_drive),
    .en       (w_drive),
    .terminal (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_DRIVE;
      ST_DRIVE: if (w_term && w_last) w_next = ST_DONE;
      ST_DONE:  if (start) w_next = ST_DRIVE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= '0;
      r_tt  <= '0;
    end else if (w_go) begin
      r_vec <= '0;
      r_tt  <= '0;
    end else if (w_drive && w_term) begin
      r_tt[r_vec] <= y_in;
      // last vector returns to 0 explicitly, not via wrap
      r_vec <= w_last ? '0 : r_vec + N_IN'(1);
    end
  end

  always_comb begin
    busy        = w_drive;
    done        = (r_state == ST_DONE);
    vec_idx     = r_vec;
    a           = r_vec[2];
    b           = r_vec[1];
    c           = r_vec[0];
    truth_table = r_tt;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus-and-capture stage that sits directly upstream of a 3-input combinational circuit under test. It drives every input vector {a,b,c} = 000..111 in ascending order and holds each vector for HOLD_CYCLES clocks. On the last hold cycle it samples the circuit's y output, then presents the captured 8-entry truth table with a done flag. This replaces hand-written delay-based stimulus with a synthesizable, clocked sweeper that on-board checks can reuse.

Parameters:
HOLD_CYCLES, 20, clocks each vector is held before y is sampled (legal range 1..255)
N_IN, 3, number of circuit inputs (fixed at 3 for this revision; table width = 2**N_IN = 8)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request a sweep; sampled only in IDLE and DONE
y_in  input  1  output of the circuit under test
a  output  1  circuit input A, MSB of vector index
b  output  1  circuit input B
c  output  1  circuit input C, LSB of vector index
vec_idx  output  3  current vector index, equal to {a,b,c}
busy  output  1  high while a sweep is in progress
done  output  1  high while a completed table is held
truth_table  output  8  captured y per vector; bit i holds y for {a,b,c}=i

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; a=b=c=0; vec_idx=0; busy=0; done=0; truth_table=8'h00; hold counter=0. Reset takes priority over every other event, including mid-sweep; a partial table is discarded.
- States: IDLE, DRIVE, DONE. Encoding is binary, 2 bits.
- IDLE: outputs hold their reset values. If start=1 at edge k, then after edge k: state=DRIVE, vec_idx=0, busy=1, hold counter=0, and truth_table is cleared to 0.
- DRIVE: {a,b,c}=vec_idx, registered and glitch-free. The hold counter increments every clock.
  - When counter==HOLD_CYCLES-1, y_in is written into truth_table[vec_idx] at that edge and the counter resets to 0.
  - If vec_idx<7, vec_idx increments at that edge.
  - If vec_idx==7, state moves to DONE at that edge: busy=0, done=1, and vec_idx and a,b,c return to 0. vec_idx does not wrap to 0 through the increment path.
- Timing: busy is high for exactly 8*HOLD_CYCLES cycles. done rises 8*HOLD_CYCLES edges after the edge that sampled start. y_in is sampled HOLD_CYCLES-1 edges after the vector was applied, which gives the DUT HOLD_CYCLES-1 clocks to settle.
- start while busy: ignored, no restart.
- DONE: done=1 and truth_table are held stable indefinitely. If start=1 at an edge, behaviour is identical to start in IDLE: done drops to 0, busy rises to 1, and the table is cleared on the same edge.
- HOLD_CYCLES=1: y_in is sampled on every clock; a vector is applied and sampled at the same edge pair.
- Hold counter width = $clog2(HOLD_CYCLES+1). No arithmetic overflow is possible within the legal range.

Decomposition:
- Shared package truth_table_pkg contains:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2
  - N_IN and TT_WIDTH=8
- One sub-module: hold_counter.
  - Ports: clk, rst, clear, en, terminal.
  - Parameterised by HOLD_CYCLES; asserts terminal when count==HOLD_CYCLES-1.
- The top level contains the FSM, the vector index register and the table register.

Test Plan:
- Reset mid-sweep: pulse rst at cycle 50 of a HOLD=20 sweep. Required: next cycle busy=0, done=0, {a,b,c}=000, truth_table=8'h00, state IDLE.
- Majority DUT, HOLD=20: pulse start once. Required:
  - {a,b,c} steps 000→111, each value held exactly 20 cycles.
  - busy is high for 160 cycles.
  - done rises after 160 edges.
  - truth_table=8'hE8.
- XOR3 DUT, HOLD=1: pulse start. Required: vectors change every cycle; busy is high for 8 cycles; truth_table=8'h96.
- start held high continuously through a sweep, HOLD=4. Required: no restart while busy. On reaching DONE the sweep restarts the next edge: done is high for 1 cycle, then busy=1 and the table is cleared.
- Settle check with y_in delayed 19 cycles from the vector change, HOLD=20, DUT y=a&b&c. Required: truth_table=8'h80. With the delay set to 20 cycles, truth_table=8'h00, which confirms the sample point is the last hold cycle.
- Idle stability: after done, hold start=0 for 100 cycles while toggling y_in randomly. Required: truth_table, done and {a,b,c}=000 are unchanged.
